// File: rtl/glcm_pkg.sv
// rtl/glcm_pkg.sv - shared types and constants for the GLCM engine
package glcm_pkg;

    // Engine control flow, one state per AXI phase plus the counting pass
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_COUNT,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_RESP,
        S_DONE
    } state_e;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_DIAG  = 2'b11;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_16     = 4'hF;

    localparam int IMG_DIM    = 16;
    localparam int GLCM_DIM   = 32;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int GLCM_CELLS = GLCM_DIM * GLCM_DIM;

    localparam logic [3:0] BEAT_LAST     = 4'd15;
    localparam logic [3:0] RD_BURST_LAST = 4'd3;
    localparam logic [3:0] WR_BURST_LAST = 4'd15;
    localparam logic [7:0] POS_LAST      = 8'hFF;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/glcm_pair_counter.sv
// rtl/glcm_pair_counter.sv - image store, pair indexing and GLCM counts (GLCM_SYMMETRIC_EN adds transposed counts)
module glcm_pair_counter
    import glcm_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        img_we,
    input  logic [5:0]  img_widx,
    input  logic [31:0] img_wdata,
    input  logic        cnt_en,
    input  logic [7:0]  cnt_pos,
    input  logic [1:0]  dir,
    input  logic [3:0]  dis,
    input  logic [7:0]  rd_widx,
    output logic [31:0] rd_word
);

    logic [4:0] img_q [IMG_PIXELS];
    logic [4:0] img_d [IMG_PIXELS];
    logic [7:0] cnt_q [GLCM_CELLS];
    logic [7:0] cnt_d [GLCM_CELLS];

    logic [3:0] dr;
    logic [3:0] dc;
    logic [4:0] row2;
    logic [4:0] col2;
    logic       pair_ok;
    logic [4:0] pix_a;
    logic [4:0] pix_b;
    logic [9:0] idx_ab;
`ifdef GLCM_SYMMETRIC_EN
    logic [9:0] idx_ba;
`endif

    // Locate the partner pixel of cnt_pos; a 5-bit sum overflowing past 15 means it falls off the image
    always_comb begin
        dr = '0;
        dc = '0;
        case (dir)
            DIR_RIGHT: dc = dis;
            DIR_DOWN:  dr = dis;
            DIR_DIAG: begin
                dr = dis;
                dc = dis;
            end
            default: ;
        endcase
        row2    = {1'b0, cnt_pos[7:4]} + {1'b0, dr};
        col2    = {1'b0, cnt_pos[3:0]} + {1'b0, dc};
        pair_ok = (dir != DIR_NONE) && !row2[4] && !col2[4];
        pix_a   = img_q[cnt_pos];
        pix_b   = img_q[{row2[3:0], col2[3:0]}];
        idx_ab  = {pix_a, pix_b};
`ifdef GLCM_SYMMETRIC_EN
        idx_ba  = {pix_b, pix_a};
`endif
    end

    // Unpack one little-endian read word into four pixels, keeping only the 5 gray-level bits
    always_comb begin
        img_d = img_q;
        if (img_we) begin
            for (int b = 0; b < 4; b++) begin
                img_d[{img_widx, 2'(b)}] = img_wdata[8*b +: 5];
            end
        end
    end

    // Clear on a new command, otherwise bump the cell addressed by the current pixel pair
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            for (int i = 0; i < GLCM_CELLS; i++) begin
                cnt_d[i] = '0;
            end
        end else if (cnt_en && pair_ok) begin
`ifdef GLCM_SYMMETRIC_EN
            cnt_d[idx_ab] = sat_inc(cnt_d[idx_ab]);
            cnt_d[idx_ba] = sat_inc(cnt_d[idx_ba]);
`else
            cnt_d[idx_ab] = cnt_d[idx_ab] + 8'd1;
`endif
        end
    end

    // Storage arrays carry no reset; every command clears the counts before use
    always_ff @(posedge clk) begin
        img_q <= img_d;
        cnt_q <= cnt_d;
    end

    assign rd_word = {cnt_q[{rd_widx, 2'd3}], cnt_q[{rd_widx, 2'd2}],
                      cnt_q[{rd_widx, 2'd1}], cnt_q[{rd_widx, 2'd0}]};

endmodule

// File: rtl/glcm_axi_engine.sv
// rtl/glcm_axi_engine.sv - GLCM engine top: command capture, FSM and AXI4 master (GLCM_SYMMETRIC_EN selects symmetric counting)
module glcm_axi_engine
    import glcm_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr_M,
    input  logic [ADDR_WIDTH-1:0] in_addr_G,
    input  logic [1:0]            in_dir,
    input  logic [3:0]            in_dis,
    output logic                  out_valid,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [3:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,
    output logic [ID_WIDTH-1:0]   awid_m_inf,
    output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
    output logic [3:0]            awlen_m_inf,
    output logic [2:0]            awsize_m_inf,
    output logic [1:0]            awburst_m_inf,
    output logic                  awvalid_m_inf,
    input  logic                  awready_m_inf,
    output logic [DATA_WIDTH-1:0] wdata_m_inf,
    output logic                  wlast_m_inf,
    output logic                  wvalid_m_inf,
    input  logic                  wready_m_inf,
    input  logic [ID_WIDTH-1:0]   bid_m_inf,
    input  logic [1:0]            bresp_m_inf,
    input  logic                  bvalid_m_inf,
    output logic                  bready_m_inf
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_m_q, addr_m_d;
    logic [ADDR_WIDTH-1:0] addr_g_q, addr_g_d;
    logic [1:0]            dir_q, dir_d;
    logic [3:0]            dis_q, dis_d;
    logic [3:0]            burst_q, burst_d;
    logic [3:0]            beat_q, beat_d;
    logic [7:0]            pos_q, pos_d;

    logic                  clr;
    logic                  img_we;
    logic                  cnt_en;
    logic [31:0]           rd_word;
    logic [ADDR_WIDTH-1:0] burst_off;
    logic                  unused_inputs;

    assign arid_m_inf    = '0;
    assign awid_m_inf    = '0;
    assign arlen_m_inf   = AXI_LEN_16;
    assign awlen_m_inf   = AXI_LEN_16;
    assign arsize_m_inf  = AXI_SIZE_4B;
    assign awsize_m_inf  = AXI_SIZE_4B;
    assign arburst_m_inf = AXI_BURST_INCR;
    assign awburst_m_inf = AXI_BURST_INCR;
    assign unused_inputs = ^{rid_m_inf, rresp_m_inf, rlast_m_inf, bid_m_inf, bresp_m_inf};

    // Every burst moves 64 bytes, so the burst number scaled by 64 is the offset from either base
    assign burst_off = ADDR_WIDTH'({burst_q, 6'd0});

    // State and command registers; reset returns to IDLE from any phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_m_q <= '0;
            addr_g_q <= '0;
            dir_q    <= '0;
            dis_q    <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_m_q <= addr_m_d;
            addr_g_q <= addr_g_d;
            dir_q    <= dir_d;
            dis_q    <= dis_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            pos_q    <= pos_d;
        end
    end

    // Next-state and burst/beat/pixel sequencing; beats are counted locally so rlast is not needed
    always_comb begin
        state_d  = state_q;
        addr_m_d = addr_m_q;
        addr_g_d = addr_g_q;
        dir_d    = dir_q;
        dis_d    = dis_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        pos_d    = pos_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_m_d = in_addr_M;
                    addr_g_d = in_addr_G;
                    dir_d    = in_dir;
                    dis_d    = in_dis;
                    burst_d  = '0;
                    beat_d   = '0;
                    pos_d    = '0;
                    state_d  = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (arready_m_inf) begin
                    beat_d  = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid_m_inf) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == BEAT_LAST) begin
                        if (burst_q == RD_BURST_LAST) begin
                            pos_d   = '0;
                            state_d = S_COUNT;
                        end else begin
                            burst_d = burst_q + 4'd1;
                            state_d = S_RD_ADDR;
                        end
                    end
                end
            end
            S_COUNT: begin
                pos_d = pos_q + 8'd1;
                if (pos_q == POS_LAST) begin
                    burst_d = '0;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (awready_m_inf) begin
                    beat_d  = '0;
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (wready_m_inf) begin
                    beat_d = beat_q + 4'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                if (bvalid_m_inf) begin
                    if (burst_q == WR_BURST_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        burst_d = burst_q + 4'd1;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs and counter strobes; payloads are forced to zero outside their phase
    always_comb begin
        arvalid_m_inf = (state_q == S_RD_ADDR);
        araddr_m_inf  = arvalid_m_inf ? (addr_m_q + burst_off) : '0;
        rready_m_inf  = (state_q == S_RD_DATA);
        awvalid_m_inf = (state_q == S_WR_ADDR);
        awaddr_m_inf  = awvalid_m_inf ? (addr_g_q + burst_off) : '0;
        wvalid_m_inf  = (state_q == S_WR_DATA);
        wdata_m_inf   = wvalid_m_inf ? rd_word : '0;
        wlast_m_inf   = wvalid_m_inf && (beat_q == BEAT_LAST);
        bready_m_inf  = (state_q == S_WR_RESP);
        out_valid     = (state_q == S_DONE);
        clr           = (state_q == S_IDLE) && in_valid;
        img_we        = rready_m_inf && rvalid_m_inf;
        cnt_en        = (state_q == S_COUNT);
    end

    glcm_pair_counter u_counter (
        .clk       (clk),
        .clr       (clr),
        .img_we    (img_we),
        .img_widx  ({burst_q[1:0], beat_q}),
        .img_wdata (rdata_m_inf),
        .cnt_en    (cnt_en),
        .cnt_pos   (pos_q),
        .dir       (dir_q),
        .dis       (dis_q),
        .rd_widx   ({burst_q, beat_q}),
        .rd_word   (rd_word)
    );

endmodule

// File: tb/tb_glcm_axi_engine.sv
// tb/tb_glcm_axi_engine.sv - self-checking bench for glcm_axi_engine with a DRAM slave model
module tb_glcm_axi_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_addr_M, in_addr_G;
    logic [1:0]  in_dir;
    logic [3:0]  in_dis;
    logic        out_valid;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

    glcm_axi_engine #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr_M(in_addr_M), .in_addr_G(in_addr_G),
        .in_dir(in_dir), .in_dis(in_dis), .out_valid(out_valid),
        .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
        .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
        .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
        .rvalid_m_inf(rvalid), .rready_m_inf(rready),
        .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awlen_m_inf(awlen), .awsize_m_inf(awsize),
        .awburst_m_inf(awburst), .awvalid_m_inf(awvalid), .awready_m_inf(awready),
        .wdata_m_inf(wdata), .wlast_m_inf(wlast), .wvalid_m_inf(wvalid), .wready_m_inf(wready),
        .bid_m_inf(bid), .bresp_m_inf(bresp), .bvalid_m_inf(bvalid), .bready_m_inf(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [8192];
    int exp_g [1024];
    int checks = 0;
    int errors = 0;
    int max_stall = 0;
    int ov_count = 0;
    int b_count = 0;

    int ar_wait, r_left, r_wait, aw_wait, w_left, w_wait, b_pend, b_wait;
    logic [31:0] ar_addr_s, r_addr, aw_addr_s, w_addr, w_data_s;

    typedef struct {
        int         pat;
        logic [1:0] dir;
        logic [3:0] dis;
        int         gi;
        int         gj;
        int         gval;
        int         gsum;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ma(input logic [31:0] a);
        return int'(a[12:0]);
    endfunction

    function automatic int stall();
        return int'($urandom_range(max_stall, 0));
    endfunction

    task automatic slave_reset();
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        ar_wait = -1; r_left = 0; r_wait = 0; aw_wait = -1; w_left = 0; w_wait = -1; b_pend = 0; b_wait = 0;
    endtask

    // DRAM slave: at each falling edge retire handshakes of the last rising edge, then offer the next ones
    initial begin
        rid = '0; rresp = '0; bid = '0; bresp = '0;
        slave_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_reset();
            end else begin
                if (arready) begin arready = 0; ar_wait = -1; r_addr = ar_addr_s; r_left = 16; r_wait = stall(); end
                if (rvalid) begin rvalid = 0; rlast = 0; r_addr += 4; r_left--; end
                if (awready) begin awready = 0; aw_wait = -1; w_addr = aw_addr_s; w_left = 16; w_wait = -1; end
                if (wready) begin
                    wready = 0;
                    for (int b = 0; b < 4; b++) mem[ma(w_addr + 32'(b))] = w_data_s[8*b +: 8];
                    w_addr += 4; w_left--; w_wait = -1;
                    if (w_left == 0) begin b_pend = 1; b_wait = stall(); end
                end
                if (bvalid) bvalid = 0;
                if (arvalid) begin
                    if (ar_wait < 0) begin
                        ar_addr_s = araddr; ar_wait = stall();
                        chk("ar_fields", {arid, arlen, arsize, arburst}, {4'h0, 4'hF, 3'b010, 2'b01});
                    end else chk("ar_addr_stable", araddr, ar_addr_s);
                    if (ar_wait == 0) arready = 1; else ar_wait--;
                end
                if (r_left > 0) begin
                    if (r_wait == 0) begin
                        chk("rready_in_data", rready, 1);
                        rvalid = 1; rlast = (r_left == 1);
                        rdata = {mem[ma(r_addr + 3)], mem[ma(r_addr + 2)], mem[ma(r_addr + 1)], mem[ma(r_addr)]};
                        r_wait = stall();
                    end else r_wait--;
                end
                if (awvalid) begin
                    if (aw_wait < 0) begin
                        aw_addr_s = awaddr; aw_wait = stall();
                        chk("aw_fields", {awid, awlen, awsize, awburst}, {4'h0, 4'hF, 3'b010, 2'b01});
                    end else chk("aw_addr_stable", awaddr, aw_addr_s);
                    if (aw_wait == 0) awready = 1; else aw_wait--;
                end
                if (wvalid && w_left > 0) begin
                    if (w_wait < 0) begin
                        w_data_s = wdata; w_wait = stall();
                        chk("wlast", wlast, (w_left == 1));
                    end else chk("wdata_stable", wdata, w_data_s);
                    if (w_wait == 0) wready = 1; else w_wait--;
                end
                if (b_pend != 0) begin
                    if (b_wait == 0) begin
                        chk("bready_in_resp", bready, 1);
                        bvalid = 1; b_pend = 0; b_count++;
                    end else b_wait--;
                end
            end
        end
    end

    // Count every cycle in which out_valid is seen high
    initial begin
        forever begin
            @(posedge clk); #1;
            if (out_valid) ov_count++;
        end
    end

    task automatic load_image(input logic [31:0] am, input int pat);
        logic [7:0] v;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (pat)
                    0: v = 8'h00;
                    1: v = 8'(c);
                    2: v = 8'((r + c) % 32);
                    3: v = 8'hE5;
                    default: v = 8'($urandom);
                endcase
                mem[ma(am + 32'(16 * r + c))] = v;
            end
        end
    endtask

    // Reference: count every in-image pixel pair at offset (dr,dc) straight from the byte image
    task automatic compute_model(input logic [31:0] am, input logic [1:0] dir, input logic [3:0] dis);
        int dr, dc, a, b;
        for (int i = 0; i < 1024; i++) exp_g[i] = 0;
        dr = (dir == 2'b10 || dir == 2'b11) ? int'(dis) : 0;
        dc = (dir == 2'b01 || dir == 2'b11) ? int'(dis) : 0;
        if (dir != 2'b00) begin
            for (int r = 0; r + dr <= 15; r++) begin
                for (int c = 0; c + dc <= 15; c++) begin
                    a = int'(mem[ma(am + 32'(16 * r + c))] & 8'h1F);
                    b = int'(mem[ma(am + 32'(16 * (r + dr) + c + dc))] & 8'h1F);
                    exp_g[a * 32 + b]++;
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] am, input logic [31:0] ag, input logic [1:0] dir, input logic [3:0] dis);
        @(negedge clk);
        in_valid = 1; in_addr_M = am; in_addr_G = ag; in_dir = dir; in_dis = dis;
        @(negedge clk);
        in_valid = 0; in_addr_M = $urandom; in_addr_G = $urandom; in_dir = 2'($urandom); in_dis = 4'($urandom);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_ctl"}, {arvalid, awvalid, wvalid, wlast, rready, bready, out_valid}, 0);
        chk({name, "_addr"}, {araddr, awaddr}, 0);
        chk({name, "_wdata"}, wdata, 0);
    endtask

    task automatic run_cmd(input string name, input logic [31:0] am, input logic [31:0] ag,
                           input logic [1:0] dir, input logic [3:0] dis, input bit poke);
        int cyc, ov0, bad;
        bit done;
        for (int i = 0; i < 1024; i++) mem[ma(ag + 32'(i))] = 8'hA5;
        compute_model(am, dir, dis);
        b_count = 0;
        ov0 = ov_count;
        issue(am, ag, dir, dis);
        cyc = 0;
        done = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) done = 1;
            if (poke && cyc == 50) begin
                @(negedge clk);
                in_valid = 1; in_addr_M = $urandom; in_addr_G = $urandom; in_dir = 2'b11; in_dis = 4'd1;
                @(negedge clk);
                in_valid = 0;
            end
        end
        chk({name, "_done_seen"}, done, 1);
        if (done) begin
            chk({name, "_b_count_at_done"}, b_count, 16);
            chk({name, "_done_follows_b"}, bvalid, 1);
            if (max_stall == 0) chk({name, "_latency_ok"}, (cyc <= 3000), 1);
            @(posedge clk); #1;
            chk({name, "_out_valid_width"}, out_valid, 0);
            bad = 0;
            for (int i = 0; i < 1024; i++) if (int'(mem[ma(ag + 32'(i))]) != exp_g[i]) bad++;
            chk({name, "_glcm_bad_bytes"}, bad, 0);
            chk({name, "_out_valid_pulses"}, ov_count - ov0, 1);
        end
    endtask

    initial begin
        logic [31:0] am, ag;
        int sum;
        in_valid = 0; in_addr_M = 0; in_addr_G = 0; in_dir = 0; in_dis = 0; rst_n = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        vecs[0] = '{0, 2'b01, 4'd1,  0, 0,  240, 240};
        vecs[1] = '{1, 2'b10, 4'd15, 7, 7,  1,   16};
        vecs[2] = '{2, 2'b11, 4'd15, 0, 30, 1,   1};
        vecs[3] = '{3, 2'b01, 4'd1,  5, 5,  240, 240};
        vecs[4] = '{0, 2'b00, 4'd3,  0, 0,  0,   0};
        vecs[5] = '{1, 2'b01, 4'd15, 0, 15, 16,  16};

        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        chk("reset_const_fields", {arlen, awlen, arsize, awsize, arburst, awburst},
            {4'hF, 4'hF, 3'b010, 3'b010, 2'b01, 2'b01});
        @(negedge clk);
        rst_n = 1;

        max_stall = 0;
        for (int k = 0; k < 6; k++) begin
            am = 32'h8000_0000 | 32'(64 * (k + 1));
            ag = 32'h0000_1000 | 32'(64 * k);
            load_image(am, vecs[k].pat);
            run_cmd($sformatf("vec%0d", k), am, ag, vecs[k].dir, vecs[k].dis, 0);
            chk($sformatf("vec%0d_key_cell", k), mem[ma(ag + 32'(32 * vecs[k].gi + vecs[k].gj))], vecs[k].gval);
            sum = 0;
            for (int i = 0; i < 1024; i++) sum += int'(mem[ma(ag + 32'(i))]);
            chk($sformatf("vec%0d_sum", k), sum, vecs[k].gsum);
        end

        max_stall = 5;
        for (int k = 0; k < 5; k++) begin
            am = ($urandom & 32'hFFFF_E000) | 32'(64 * $urandom_range(44, 0));
            ag = ($urandom & 32'hFFFF_E000) | 32'h1000 | 32'(64 * $urandom_range(47, 0));
            load_image(am, 4);
            run_cmd($sformatf("rnd%0d", k), am, ag, 2'($urandom_range(3, 0)), 4'($urandom_range(15, 1)), (k % 2) == 1);
        end

        max_stall = 3;
        am = 32'h0000_0200;
        ag = 32'h0000_1400;
        load_image(am, 4);
        for (int i = 0; i < 1024; i++) mem[ma(ag + 32'(i))] = 8'h5A;
        issue(am, ag, 2'b01, 4'd2);
        begin
            int n;
            n = 0;
            while (!rready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rst_reach_rd_data", rready, 1);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_quiet($sformatf("midrst%0d", k));
        end
        @(negedge clk);
        rst_n = 1;
        am = 32'h0000_0400;
        load_image(am, 4);
        run_cmd("post_rst", am, ag, 2'b11, 4'd4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
